div_phase_sched: RTL and testbench

Scheduler and configurator for the phase-delayed 50 kHz clock dividers used by the 2ASK/QPSK modulators.
- Generates NCH divided clocks from clk50m, with a shared half-period and a per-channel start delay (e.g. I/Q symbol clocks offset in phase).
- Sequences start-up (arm, staggered start, run) and accepts runtime reconfiguration through a valid/ready handshake.
- Reconfiguration is applied glitch-free, only on a channel-0 period boundary.

---
 rtl/div_sched_pkg.sv | 15 +
 rtl/div_phase_chan.sv | 44 ++++
 rtl/div_phase_sched.sv | 148 ++++++++++++++
 tb/tb_div_phase_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// Shared constants for the phase-delayed divided-clock scheduler.
// State codes are plain constants so legacy code can still compare them directly.
package div_sched_pkg;

   localparam int unsigned CNT_W_DEF    = 30;
   localparam int unsigned DEF_HALF_50K = 499;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t ARM    = 2'd1;
   localparam state_t RUN    = 2'd2;
   localparam state_t RELOAD = 2'd3;

endpackage

// File: rtl/div_phase_chan.sv
// One divided-clock channel: counts half-periods while enabled and toggles clk_out.
// tick marks each rising edge; fall flags the cycle whose edge turns clk_out 1->0.
module div_phase_chan
   import div_sched_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk50m,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] half,
   output logic             clk_out,
   output logic             tick,
   output logic             fall
);

   logic [CNT_W-1:0] pcnt;
   logic             wrap;

   assign wrap = en & (pcnt == half);
   assign fall = wrap & clk_out;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         pcnt    <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (clr) begin
         pcnt    <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         tick <= wrap & ~clk_out;
         if (wrap) begin
            pcnt    <= '0;
            clk_out <= ~clk_out;
         end else if (en) begin
            pcnt <= pcnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_phase_sched.sv
// Scheduler for NCH phase-delayed divided clocks: arm/stagger/run sequencing plus
// reconfiguration applied on a channel-0 period boundary. Optional macro: DIV_SCHED_PERIOD_CNT_EN.
module div_phase_sched
   import div_sched_pkg::*;
#(
   parameter int unsigned NCH      = 2,
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned DEF_HALF = DEF_HALF_50K
) (
   input  logic                 clk50m,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CNT_W-1:0]     cfg_half,
   input  logic [NCH*CNT_W-1:0] cfg_delay,
   output logic                 cfg_err,
   output logic                 busy,
   output logic [NCH-1:0]       clk_out,
   output logic [NCH-1:0]       tick,
   output logic [15:0]          period_cnt
);

   localparam logic [NCH-1:0] RELOAD_SRC = NCH'(1);

   state_t               state, state_nx;
   logic [CNT_W-1:0]     half_r, sh_half, dcnt;
   logic [NCH*CNT_W-1:0] delay_r, sh_delay;
   logic                 pending, err_r;
   logic [NCH-1:0]       en, en_eff, fall;
   logic                 accept, cfg_ok, drop, go_reload, all_en, chan_clr;

   assign cfg_ready = (state == IDLE) | ((state == RUN) & ~pending);
   assign busy      = (state != IDLE);
   assign cfg_err   = err_r;
   assign accept    = cfg_valid & cfg_ready;
   assign cfg_ok    = accept & (cfg_half != '0);
   assign drop      = (state != IDLE) & ~run;
   // Only channel 0 paces reloads; the mask keeps the selection explicit.
   assign go_reload = (state == RUN) & run & pending & (|(fall & RELOAD_SRC));
   assign all_en    = &en_eff;
   assign chan_clr  = ~((state == ARM) | (state == RUN)) | ~run | go_reload;

   // A channel counts from the very cycle its delay matches, ahead of the en register.
   always_comb begin
      en_eff = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         en_eff[i] = en[i] | ((state == ARM) && (dcnt == delay_r[i*CNT_W +: CNT_W]));
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (run) state_nx = ARM;
         ARM:     if (!run) state_nx = IDLE; else if (all_en) state_nx = RUN;
         RUN:     if (!run) state_nx = IDLE; else if (go_reload) state_nx = RELOAD;
         RELOAD:  state_nx = run ? ARM : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         half_r   <= CNT_W'(DEF_HALF);
         delay_r  <= '0;
         sh_half  <= '0;
         sh_delay <= '0;
         pending  <= 1'b0;
         dcnt     <= '0;
         en       <= '0;
         err_r    <= 1'b0;
      end else begin
         state <= state_nx;
         err_r <= accept & (cfg_half == '0) & ~drop;
         case (state)
            IDLE: begin
               dcnt    <= '0;
               en      <= '0;
               pending <= 1'b0;
               if (cfg_ok) begin
                  half_r  <= cfg_half;
                  delay_r <= cfg_delay;
               end
            end
            ARM: begin
               if (dcnt != '1) dcnt <= dcnt + 1'b1;
               en <= run ? en_eff : '0;
            end
            RUN: begin
               if (!run) begin
                  en      <= '0;
                  pending <= 1'b0;
               end else begin
                  if (go_reload) en <= '0;
                  if (cfg_ok) begin
                     sh_half  <= cfg_half;
                     sh_delay <= cfg_delay;
                     pending  <= 1'b1;
                  end
               end
            end
            default: begin
               dcnt    <= '0;
               en      <= '0;
               pending <= 1'b0;
               if (run) begin
                  half_r  <= sh_half;
                  delay_r <= sh_delay;
               end
            end
         endcase
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      div_phase_chan #(.CNT_W(CNT_W)) u_chan (
         .clk50m  (clk50m),
         .rst_n   (rst_n),
         .en      (en_eff[g]),
         .clr     (chan_clr),
         .half    (half_r),
         .clk_out (clk_out[g]),
         .tick    (tick[g]),
         .fall    (fall[g])
      );
   end

`ifdef DIV_SCHED_PERIOD_CNT_EN
   logic [15:0] pc_r;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= '0;
      end else if ((state == IDLE) || (state == RELOAD) || drop) begin
         pc_r <= '0;
      end else if (tick[0]) begin
         pc_r <= pc_r + 1'b1;
      end
   end

   assign period_cnt = pc_r;
`else
   assign period_cnt = '0;
`endif

endmodule

// File: tb/tb_div_phase_sched.sv
// Directed bench for div_phase_sched: staggered start, default 50 kHz, reload, reject, stop, reset.
module tb_div_phase_sched;

   logic        clk50m = 1'b0;
   logic        rst_n, run, cfg_valid, cfg_ready, cfg_err, busy;
   logic [29:0] cfg_half;
   logic [59:0] cfg_delay;
   logic [1:0]  clk_out, tick;
   logic [15:0] period_cnt;

   int total = 0;
   int bad   = 0;
   int k;
   bit m_on;
   int m_base, m_h, m_d0, m_d1;

`ifdef DIV_SCHED_PERIOD_CNT_EN
   localparam bit PC_EN = 1'b1;
`else
   localparam bit PC_EN = 1'b0;
`endif

   div_phase_sched #(.NCH(2), .CNT_W(30), .DEF_HALF(499)) dut (
      .clk50m     (clk50m),
      .rst_n      (rst_n),
      .run        (run),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_half   (cfg_half),
      .cfg_delay  (cfg_delay),
      .cfg_err    (cfg_err),
      .busy       (busy),
      .clk_out    (clk_out),
      .tick       (tick),
      .period_cnt (period_cnt)
   );

   always #10 clk50m = ~clk50m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
      end
   endtask

   // Expected level of a channel at sample kk, from ARM entry at m_base.
   function automatic logic lvl(input int kk, input int d);
      int first;
      first = m_base + d + m_h + 1;
      if (kk < first) return 1'b0;
      return (((kk - first) / (m_h + 1)) % 2) == 0;
   endfunction

   function automatic logic tk(input int kk, input int d);
      int first;
      first = m_base + d + m_h + 1;
      return (kk >= first) && (((kk - first) % (2 * (m_h + 1))) == 0);
   endfunction

   function automatic int pcx(input int v);
      return PC_EN ? v : 0;
   endfunction

   task automatic step();
      @(posedge clk50m);
      #1;
      k++;
      if (m_on) begin
         chk("clk_out", clk_out, {lvl(k, m_d1), lvl(k, m_d0)});
         chk("tick", tick, {tk(k, m_d1), tk(k, m_d0)});
      end
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_half = '0; cfg_delay = '0;
      m_on = 1'b0; k = 0; m_base = 0; m_h = 0; m_d0 = 0; m_d1 = 0;
      #25;
      chk("rst_clk", clk_out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_err", cfg_err, 0);
      chk("rst_pc", period_cnt, 0);
      @(posedge clk50m);
      #1;
      rst_n = 1'b1;
      step(); step();
      chk("idle_ready", cfg_ready, 1);
      chk("idle_clk", clk_out, 0);

      // Config offered together with run: half=4, ch1 delayed by 3
      cfg_valid = 1'b1; cfg_half = 30'd4; cfg_delay = {30'd3, 30'd0}; run = 1'b1;
      m_on = 1'b1; m_base = 0; m_h = 4; m_d0 = 0; m_d1 = 3; k = -1;
      step();
      cfg_valid = 1'b0;
      chk("arm_busy", busy, 1);
      chk("arm_ready", cfg_ready, 0);
      repeat (3) step();
      chk("arm_ready3", cfg_ready, 0);
      step();
      chk("run_ready", cfg_ready, 1);
      repeat (23) step();
      chk("pc_3", period_cnt, pcx(3));
      repeat (14) step();

      // Reload to half=9, ch1 delay 2; takes effect at the channel-0 fall at k=50
      chk("pre_cfg_ready", cfg_ready, 1);
      cfg_valid = 1'b1; cfg_half = 30'd9; cfg_delay = {30'd2, 30'd0};
      step();
      cfg_valid = 1'b0;
      chk("pend_ready", cfg_ready, 0);
      chk("pend_err", cfg_err, 0);
      repeat (7) step();
      chk("pend_ready49", cfg_ready, 0);
      m_on = 1'b0;
      step();
      chk("reload_clk", clk_out, 0);
      chk("reload_tick", tick, 0);
      chk("reload_busy", busy, 1);
      chk("reload_ready", cfg_ready, 0);
      chk("reload_pc", period_cnt, pcx(5));
      m_on = 1'b1; m_base = 51; m_h = 9; m_d0 = 0; m_d1 = 2;
      step();
      chk("rearm_pc", period_cnt, 0);
      chk("rearm_busy", busy, 1);
      repeat (2) step();
      chk("rearm_ready", cfg_ready, 0);
      step();
      chk("rerun_ready", cfg_ready, 1);
      repeat (46) step();

      // Rejected config: handshake completes, error pulse, pattern unchanged
      cfg_valid = 1'b1; cfg_half = '0; cfg_delay = '0;
      step();
      cfg_valid = 1'b0;
      chk("rej_err", cfg_err, 1);
      chk("rej_ready", cfg_ready, 1);
      step();
      chk("rej_err_end", cfg_err, 0);
      repeat (41) step();
      chk("pre_stop_clk", clk_out, 2'b11);

      // Stop mid-RUN
      run = 1'b0; m_on = 1'b0;
      step();
      chk("stop_clk", clk_out, 0);
      chk("stop_tick", tick, 0);
      chk("stop_busy", busy, 0);
      chk("stop_ready", cfg_ready, 1);
      chk("stop_pc", period_cnt, 0);

      // Stop mid-ARM (ch1 delayed by 20, ch0 already toggling)
      cfg_valid = 1'b1; cfg_half = 30'd4; cfg_delay = {30'd20, 30'd0}; run = 1'b1;
      m_on = 1'b1; m_base = 0; m_h = 4; m_d0 = 0; m_d1 = 20; k = -1;
      step();
      cfg_valid = 1'b0;
      repeat (6) step();
      chk("marm_busy", busy, 1);
      chk("marm_clk", clk_out, 2'b01);
      run = 1'b0; m_on = 1'b0;
      step();
      chk("marm_stop_clk", clk_out, 0);
      chk("marm_stop_tick", tick, 0);
      chk("marm_stop_busy", busy, 0);

      // Restart, then reset asserted mid-RUN
      run = 1'b1; m_on = 1'b1; k = -1;
      step();
      repeat (36) step();
      chk("pre_rst_clk", clk_out, 2'b11);
      chk("pre_rst_busy", busy, 1);
      chk("pre_rst_pc", period_cnt, pcx(4));
      m_on = 1'b0;
      #2;
      rst_n = 1'b0; run = 1'b0;
      #1;
      chk("arst_clk", clk_out, 0);
      chk("arst_tick", tick, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", cfg_ready, 1);
      chk("arst_err", cfg_err, 0);
      chk("arst_pc", period_cnt, 0);
      #6;
      rst_n = 1'b1;
      step();
      chk("post_rst_busy", busy, 0);

      // Default config: 1000-cycle period on both channels
      run = 1'b1; m_on = 1'b1; m_base = 0; m_h = 499; m_d0 = 0; m_d1 = 0; k = -1;
      step();
      repeat (1600) step();
      chk("def_busy", busy, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
